// File: rtl/keypad_scanner.sv
// keypad_scanner: scans a 4x4 matrix keypad and debounces press and release of a single key.
// Latency: 2 (sync) + up to 4*SCAN_DIV (scan) + DB_CYCLES + 1 clocks from a stable press to key_pulse.
// Backpressure: none; key_pulse is a one-clock strobe and col_row_comb holds the last accepted key.
module keypad_scanner #(
  parameter int SCAN_DIV  = 1000,
  parameter int DB_CYCLES = 20000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] rows,
  output logic [3:0] cols,
  output logic [8:0] col_row_comb,
  output logic       key_pulse
);

  // One counter serves both the column dwell and the debounce windows.
  localparam int CNT_MAX = (SCAN_DIV > DB_CYCLES) ? SCAN_DIV : DB_CYCLES;
  localparam int CW      = $clog2(CNT_MAX);
  localparam logic [CW-1:0] SCAN_LAST = CW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] DB_LAST   = CW'(DB_CYCLES - 1);

  typedef enum logic [1:0] {
    SCAN     = 2'd0,
    DEBOUNCE = 2'd1,
    HELD     = 2'd2,
    RELEASE  = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [3:0]    sync1_q, sync1_d;
  logic [3:0]    rs_q, rs_d;
  logic [3:0]    col_q, col_d;
  logic [3:0]    kc_q, kc_d;
  logic [3:0]    kr_q, kr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [8:0]    crc_q, crc_d;
  logic          pulse_q, pulse_d;

  logic          rs_onehot;
  logic [3:0]    col_next;
  logic [3:0]    kc_next;

  // Exactly one row active; zero or several rows in one column are treated as no key.
  assign rs_onehot = (rs_q != 4'b0000) && ((rs_q & (rs_q - 4'd1)) == 4'b0000);
  assign col_next  = {col_q[2:0], col_q[3]};
  assign kc_next   = {kc_q[2:0], kc_q[3]};

  // Two-flop synchronizer for the asynchronous keypad rows.
  always_comb begin
    sync1_d = rows;
    rs_d    = sync1_q;
  end

  // State and datapath registers; synchronous active-low reset wins in every state.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= SCAN;
      sync1_q <= 4'b0000;
      rs_q    <= 4'b0000;
      col_q   <= 4'b0001;
      kc_q    <= 4'b0000;
      kr_q    <= 4'b0000;
      cnt_q   <= '0;
      crc_q   <= 9'h000;
      pulse_q <= 1'b0;
    end else begin
      state_q <= state_d;
      sync1_q <= sync1_d;
      rs_q    <= rs_d;
      col_q   <= col_d;
      kc_q    <= kc_d;
      kr_q    <= kr_d;
      cnt_q   <= cnt_d;
      crc_q   <= crc_d;
      pulse_q <= pulse_d;
    end
  end

  // Next-state and datapath decisions; the counter is cleared on every state entry.
  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    kc_d    = kc_q;
    kr_d    = kr_q;
    cnt_d   = cnt_q;
    crc_d   = crc_q;
    pulse_d = 1'b0;
    case (state_q)
      SCAN: begin
        if (cnt_q == SCAN_LAST) begin
          cnt_d = '0;
          if (rs_onehot) begin
            kc_d    = col_q;
            kr_d    = rs_q;
            state_d = DEBOUNCE;
          end else begin
            col_d = col_next;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DEBOUNCE: begin
        if (rs_q != kr_q) begin
          state_d = SCAN;
          cnt_d   = '0;
          col_d   = kc_next;
        end else if (cnt_q == DB_LAST) begin
          state_d = HELD;
          cnt_d   = '0;
          crc_d   = {1'b1, kc_q, kr_q};
          pulse_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      HELD: begin
        // Only the latched row matters; extra rows in this column are ignored.
        if ((rs_q & kr_q) == 4'b0000) begin
          state_d = RELEASE;
          cnt_d   = '0;
        end
      end
      RELEASE: begin
        if ((rs_q & kr_q) != 4'b0000) begin
          state_d = HELD;
          cnt_d   = '0;
        end else if (cnt_q == DB_LAST) begin
          state_d  = SCAN;
          cnt_d    = '0;
          crc_d[8] = 1'b0;
          col_d    = kc_next;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = SCAN;
        cnt_d   = '0;
        col_d   = 4'b0001;
      end
    endcase
  end

  // Outputs come straight from flops so the pins never glitch.
  always_comb begin
    cols         = col_q;
    col_row_comb = crc_q;
    key_pulse    = pulse_q;
  end

endmodule
